// File: rtl/coin_payout.sv
// coin_payout: change/refund coin payout stage. Collects change (pdt edge)
// and refund (rtn zero->nonzero) coin counts into a saturating pending
// count and feeds the hopper one coin at a time, with a gap between coins
// and a jam timeout while feeding.
// Ports: clk, rst (sync, active-high); pdt/cng change request;
//   rtn refund value; hopper_coin exit-sensor pulse; fault_clr jam clear;
//   hopper_en motor enable; busy; pending coins owed; fault sticky jam;
//   paid_total coins paid since reset.
// Build option: COIN_PAYOUT_STATS_EN enables the paid_total counter,
//   otherwise paid_total is tied to zero.
module coin_payout #(
   parameter int PAYOUT_W    = 3,
   parameter int TIMEOUT_CYC = 16,
   parameter int GAP_CYC     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pdt,
   input  logic [PAYOUT_W-1:0] cng,
   input  logic [PAYOUT_W-1:0] rtn,
   input  logic                hopper_coin,
   input  logic                fault_clr,
   output logic                hopper_en,
   output logic                busy,
   output logic [PAYOUT_W:0]   pending,
   output logic                fault,
   output logic [7:0]          paid_total
);

   localparam int PW = PAYOUT_W + 1;
   localparam int SW = PAYOUT_W + 2;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int GW = $clog2(GAP_CYC + 1);
   localparam logic [PW-1:0] P_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_GAP,
      S_FAULT
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_pdt_q;
   logic            r_rtn_nz_q;
   logic [PW-1:0]   r_pending;
   logic [TW-1:0]   r_timer;
   logic [GW-1:0]   r_gap;
   logic            r_hopper_en;

   logic            w_chg_evt;
   logic            w_rfd_evt;
   logic            w_dec;
   logic            w_timeout;
   logic            w_gap_done;
   logic            w_pend_nz;
   logic [SW-1:0]   w_sum;
   logic [PW-1:0]   w_pending_nxt;
   logic            w_hopper_en_nxt;
   logic            w_fault;
   logic            w_busy;

   assign w_chg_evt  = pdt & ~r_pdt_q;
   assign w_rfd_evt  = (|rtn) & ~r_rtn_nz_q;
   assign w_dec      = (r_state == S_FEED) & hopper_coin;
   assign w_timeout  = (r_timer == TW'(TIMEOUT_CYC - 1));
   assign w_gap_done = (r_gap == GW'(1));
   assign w_pend_nz  = |r_pending;

   // One extra bit of headroom holds max pending plus both event adds;
   // a decrement only happens in FEED, where pending is nonzero.
   always_comb begin
      w_sum = SW'(r_pending)
            + (w_chg_evt ? SW'(cng) : SW'(0))
            + (w_rfd_evt ? SW'(rtn) : SW'(0))
            - SW'(w_dec);
      if (w_sum > SW'(P_MAX)) begin
         w_pending_nxt = P_MAX;
      end else begin
         w_pending_nxt = w_sum[PW-1:0];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a coin in the timeout cycle takes priority
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_pend_nz) w_next = S_FEED;
         end
         S_FEED: begin
            if (hopper_coin)    w_next = S_GAP;
            else if (w_timeout) w_next = S_FAULT;
         end
         S_GAP: begin
            if (w_gap_done) w_next = w_pend_nz ? S_FEED : S_IDLE;
         end
         S_FAULT: begin
            if (fault_clr) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      w_hopper_en_nxt = (w_next == S_FEED);
      w_fault         = (r_state == S_FAULT);
      w_busy          = (r_state != S_IDLE) | w_pend_nz;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pdt_q     <= 1'b0;
         r_rtn_nz_q  <= 1'b0;
         r_pending   <= '0;
         r_timer     <= '0;
         r_gap       <= '0;
         r_hopper_en <= 1'b0;
      end else begin
         r_pdt_q     <= pdt;
         r_rtn_nz_q  <= |rtn;
         r_pending   <= w_pending_nxt;
         r_hopper_en <= w_hopper_en_nxt;
         // Timer restarts on every entry into FEED
         if (w_next == S_FEED && r_state != S_FEED) begin
            r_timer <= '0;
         end else if (r_state == S_FEED) begin
            r_timer <= r_timer + TW'(1);
         end
         if (w_dec) begin
            r_gap <= GW'(GAP_CYC);
         end else if (r_state == S_GAP) begin
            r_gap <= r_gap - GW'(1);
         end
      end
   end

`ifdef COIN_PAYOUT_STATS_EN
   logic [7:0] r_paid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_paid <= '0;
      end else if (w_dec) begin
         r_paid <= r_paid + 8'd1;
      end
   end

   assign paid_total = r_paid;
`else
   assign paid_total = '0;
`endif

   assign hopper_en = r_hopper_en;
   assign fault     = w_fault;
   assign busy      = w_busy;
   assign pending   = r_pending;

endmodule
